// File: rtl/adc_filter_protect_pkg.sv
// Shared definitions for the ADC filter / protection slice: code width,
// supervisory mode encodings and the fault-vector bit order.
package adc_pkg;

  localparam int ADC_W = 13;

  // Fault vector bit positions.
  localparam int FLT_W  = 4;
  localparam int FLT_OV = 0;
  localparam int FLT_OT = 1;
  localparam int FLT_OC = 2;
  localparam int FLT_UV = 3;

  typedef logic [FLT_W-1:0] fault_vec_t;

  typedef enum logic [1:0] {
    MODE_STARTUP = 2'b00,
    MODE_RUN     = 2'b01,
    MODE_TRIP    = 2'b10
  } mode_e;

endpackage

// File: rtl/adc_filter_protect_boxcar_avg.sv
// One-channel boxcar averager: sums 2^LOG2_AVG ticks, then publishes the
// truncated mean with a one-cycle valid pulse and restarts the window.
module boxcar_avg
  import adc_pkg::*;
#(
  parameter int LOG2_AVG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [ADC_W-1:0] din,
  output logic [ADC_W-1:0] dout,
  output logic             dvalid
);

  // Accumulator is wide enough for 2^LOG2_AVG full-scale samples.
  localparam int ACC_W = ADC_W + LOG2_AVG;
  // A window of one sweep still needs a 1-bit counter that never moves.
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADC_W-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;

  // Window accumulation and end-of-window publish.
  always_comb begin
    sum      = acc_q + ACC_W'(din);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (tick) begin
      if (cnt_q == CNT_LAST) begin
        acc_d    = '0;
        cnt_d    = '0;
        dout_d   = ADC_W'(sum >> LOG2_AVG);
        dvalid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

endmodule

// File: rtl/adc_filter_protect.sv
// ADC post-processing for the SMPS loop: per-channel boxcar averages,
// debounced overcurrent, averaged OV/OT/UV faults, sticky fault latches,
// registered shutdown and the STARTUP/RUN/TRIP supervisor.
// sample_tick is a one-cycle strobe (no backpressure): every high cycle
// is one sweep; avg_valid is a one-cycle pulse with no ready.
module adc_filter_protect
  import adc_pkg::*;
#(
  parameter int               LOG2_AVG = 2,
  parameter logic [ADC_W-1:0] VO_MAX   = 13'd6000,
  parameter logic [ADC_W-1:0] T_MAX    = 13'd5000,
  parameter logic [ADC_W-1:0] I_MAX    = 13'd7000,
  parameter int               OC_CNT   = 3,
  parameter logic [ADC_W-1:0] VIN_MIN  = 13'd2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             fault_clr,
  input  logic [ADC_W-1:0] adc_vo,
  input  logic [ADC_W-1:0] adc_temp,
  input  logic [ADC_W-1:0] adc_i,
  input  logic [ADC_W-1:0] adc_vin,
  output logic [ADC_W-1:0] avg_vo,
  output logic [ADC_W-1:0] avg_temp,
  output logic [ADC_W-1:0] avg_i,
  output logic [ADC_W-1:0] avg_vin,
  output logic             avg_valid,
  output logic             fault_ov,
  output logic             fault_ot,
  output logic             fault_oc,
  output logic             fault_uv,
  output logic             shutdown,
  output logic [1:0]       mode
);

  localparam logic [3:0] OC_LIM = 4'(OC_CNT);

  logic       v_vo, v_temp, v_i, v_vin;
  logic [3:0] oc_cnt_q, oc_cnt_d;
  fault_vec_t flags_q, flags_d;
  fault_vec_t set_v, cond_v;
  logic       shutdown_q, shutdown_d;
  mode_e      mode_q, mode_d;

  boxcar_avg #(.LOG2_AVG(LOG2_AVG)) u_avg_vo (
    .clk(clk), .rst(rst), .tick(sample_tick), .din(adc_vo),
    .dout(avg_vo), .dvalid(v_vo)
  );
  boxcar_avg #(.LOG2_AVG(LOG2_AVG)) u_avg_temp (
    .clk(clk), .rst(rst), .tick(sample_tick), .din(adc_temp),
    .dout(avg_temp), .dvalid(v_temp)
  );
  boxcar_avg #(.LOG2_AVG(LOG2_AVG)) u_avg_i (
    .clk(clk), .rst(rst), .tick(sample_tick), .din(adc_i),
    .dout(avg_i), .dvalid(v_i)
  );
  boxcar_avg #(.LOG2_AVG(LOG2_AVG)) u_avg_vin (
    .clk(clk), .rst(rst), .tick(sample_tick), .din(adc_vin),
    .dout(avg_vin), .dvalid(v_vin)
  );

  // All four channels share the same tick so their windows stay aligned.
  assign avg_valid = v_vo & v_temp & v_i & v_vin;

  // Overcurrent debounce: consecutive over-limit sweeps, saturating.
  always_comb begin
    oc_cnt_d = oc_cnt_q;
    if (sample_tick) begin
      if (adc_i > I_MAX) begin
        oc_cnt_d = (oc_cnt_q == OC_LIM) ? oc_cnt_q : oc_cnt_q + 4'd1;
      end else begin
        oc_cnt_d = '0;
      end
    end
  end

  // Fault latches: set events win over clear; clear only drops a flag
  // whose underlying condition is currently false.
  always_comb begin
    set_v          = '0;
    cond_v         = '0;
    cond_v[FLT_OV] = (avg_vo > VO_MAX);
    cond_v[FLT_OT] = (avg_temp > T_MAX);
    cond_v[FLT_OC] = (oc_cnt_q == OC_LIM);
    cond_v[FLT_UV] = (avg_vin < VIN_MIN);
    set_v[FLT_OV]  = avg_valid && cond_v[FLT_OV];
    set_v[FLT_OT]  = avg_valid && cond_v[FLT_OT];
    set_v[FLT_OC]  = cond_v[FLT_OC];
    set_v[FLT_UV]  = avg_valid && cond_v[FLT_UV] && (mode_q == MODE_RUN);
    flags_d        = set_v | (flags_q & ~({FLT_W{fault_clr}} & ~cond_v));
    shutdown_d     = (|flags_q) || (mode_q == MODE_TRIP);
  end

  // Supervisor next state.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      MODE_STARTUP: begin
        if (|flags_q) begin
          mode_d = MODE_TRIP;
        end else if (avg_valid && (avg_vin >= VIN_MIN) && (flags_d == '0)) begin
          mode_d = MODE_RUN;
        end
      end
      MODE_RUN: begin
        if (|flags_q) mode_d = MODE_TRIP;
      end
      MODE_TRIP: begin
        if (fault_clr && (flags_d == '0)) mode_d = MODE_STARTUP;
      end
      default: mode_d = MODE_STARTUP;
    endcase
  end

  // Protection and supervisor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      oc_cnt_q   <= '0;
      flags_q    <= '0;
      shutdown_q <= 1'b0;
      mode_q     <= MODE_STARTUP;
    end else begin
      oc_cnt_q   <= oc_cnt_d;
      flags_q    <= flags_d;
      shutdown_q <= shutdown_d;
      mode_q     <= mode_d;
    end
  end

  assign fault_ov = flags_q[FLT_OV];
  assign fault_ot = flags_q[FLT_OT];
  assign fault_oc = flags_q[FLT_OC];
  assign fault_uv = flags_q[FLT_UV];
  assign shutdown = shutdown_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_adc_filter_protect.sv
// Bench for adc_filter_protect: directed scenarios plus randomized sweeps
// checked against a sweep-level behavioural model.
module tb_adc_filter_protect;

  localparam logic [1:0] M_STARTUP = 2'd0;
  localparam logic [1:0] M_RUN     = 2'd1;
  localparam logic [1:0] M_TRIP    = 2'd2;
  localparam int N_AVG = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst = 1'b1, sample_tick = 1'b0, fault_clr = 1'b0;
  logic [12:0] adc_vo = '0, adc_temp = '0, adc_i = '0, adc_vin = '0;
  logic [12:0] avg_vo, avg_temp, avg_i, avg_vin;
  logic        avg_valid, fault_ov, fault_ot, fault_oc, fault_uv, shutdown;
  logic [1:0]  mode;
  logic [12:0] avg_vo6, avg_temp6, avg_i6, avg_vin6;
  logic        avg_valid6, fault_ov6, fault_ot6, fault_oc6, fault_uv6, shutdown6;
  logic [1:0]  mode6;

  adc_filter_protect #(.LOG2_AVG(2)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .fault_clr(fault_clr),
    .adc_vo(adc_vo), .adc_temp(adc_temp), .adc_i(adc_i), .adc_vin(adc_vin),
    .avg_vo(avg_vo), .avg_temp(avg_temp), .avg_i(avg_i), .avg_vin(avg_vin),
    .avg_valid(avg_valid), .fault_ov(fault_ov), .fault_ot(fault_ot),
    .fault_oc(fault_oc), .fault_uv(fault_uv), .shutdown(shutdown), .mode(mode)
  );

  adc_filter_protect #(.LOG2_AVG(6)) dut6 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .fault_clr(fault_clr),
    .adc_vo(adc_vo), .adc_temp(adc_temp), .adc_i(adc_i), .adc_vin(adc_vin),
    .avg_vo(avg_vo6), .avg_temp(avg_temp6), .avg_i(avg_i6), .avg_vin(avg_vin6),
    .avg_valid(avg_valid6), .fault_ov(fault_ov6), .fault_ot(fault_ot6),
    .fault_oc(fault_oc6), .fault_uv(fault_uv6), .shutdown(shutdown6), .mode(mode6)
  );

  int checks = 0;
  int errors = 0;

  logic [12:0] act_avg [4];
  logic [3:0]  act_flags;
  always_comb begin
    act_avg[0] = avg_vo;
    act_avg[1] = avg_temp;
    act_avg[2] = avg_i;
    act_avg[3] = avg_vin;
    act_flags  = {fault_uv, fault_oc, fault_ot, fault_ov};
  end

  // Reference model (sweep granularity) and scoreboard queue
  logic [12:0] exp_q [$];
  int          m_sum [4];
  int          m_avg [4];
  int          m_n, m_ocrun, m_mode;
  logic        m_ov, m_ot, m_oc, m_uv, m_done;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin m_sum[k] = 0; m_avg[k] = 0; end
    m_n = 0; m_ocrun = 0; m_mode = 0; m_done = 1'b0;
    m_ov = 1'b0; m_ot = 1'b0; m_oc = 1'b0; m_uv = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_tick(int vo, int t, int i, int vin);
    m_sum[0] += vo; m_sum[1] += t; m_sum[2] += i; m_sum[3] += vin;
    m_n++;
    if (i > 7000) m_ocrun = (m_ocrun < 3) ? m_ocrun + 1 : 3;
    else          m_ocrun = 0;
    m_done = (m_n == N_AVG);
    if (m_done) begin
      for (int k = 0; k < 4; k++) begin m_avg[k] = m_sum[k] / N_AVG; m_sum[k] = 0; end
      m_n = 0;
      exp_q.push_back(13'(m_avg[0]));
    end
    if (m_done && m_avg[0] > 6000) m_ov = 1'b1;
    if (m_done && m_avg[1] > 5000) m_ot = 1'b1;
    if (m_ocrun == 3) m_oc = 1'b1;
    if (m_done && m_mode == 1 && m_avg[3] < 2000) m_uv = 1'b1;
    if (m_ov || m_ot || m_oc || m_uv) m_mode = 2;
    else if (m_mode == 0 && m_done && m_avg[3] >= 2000) m_mode = 1;
  endfunction

  function automatic void model_clear();
    if (m_avg[0] <= 6000) m_ov = 1'b0;
    if (m_avg[1] <= 5000) m_ot = 1'b0;
    if (m_ocrun < 3) m_oc = 1'b0;
    if (m_avg[3] >= 2000) m_uv = 1'b0;
    if (m_mode == 2 && !(m_ov || m_ot || m_oc || m_uv)) m_mode = 0;
  endfunction

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_tick = 1'b0; fault_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge of the cycle right after the tick was sampled.
  task automatic drive_tick(input logic [12:0] vo, t, i, vin);
    @(negedge clk);
    adc_vo = vo; adc_temp = t; adc_i = i; adc_vin = vin;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nominal_window(input logic [12:0] vo, t, vin);
    for (int k = 0; k < 4; k++) drive_tick(vo, t, 13'd1000, vin);
    idle(4);
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; sample_tick = 1'b1;
    adc_vo = 13'd8000; adc_temp = 13'd8000; adc_i = 13'd8000; adc_vin = 13'd100;
    idle(3);
    checks++;
    if ({avg_vo, avg_temp, avg_i, avg_vin, avg_valid, fault_ov, fault_ot, fault_oc,
         fault_uv, shutdown, mode} !== '0) begin
      errors++; $display("FAIL reset_outputs: dut outputs not all zero (mode=%0d shutdown=%0b)", mode, shutdown);
    end
    checks++;
    if ({avg_vo6, avg_temp6, avg_i6, avg_vin6, avg_valid6, fault_ov6, fault_ot6, fault_oc6,
         fault_uv6, shutdown6, mode6} !== '0) begin
      errors++; $display("FAIL reset_outputs6: dut6 outputs not all zero (mode=%0d)", mode6);
    end
    sample_tick = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_averaging();
    logic [12:0] vals [4];
    vals[0] = 13'd100; vals[1] = 13'd200; vals[2] = 13'd300; vals[3] = 13'd401;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_tick(vals[k], 13'd1000, 13'd1000, 13'd3000);
      checks++;
      if (avg_valid !== (k == 3)) begin
        errors++; $display("FAIL avg_valid_timing: tick %0d avg_valid=%0b required %0b", k, avg_valid, (k == 3));
      end
    end
    checks++;
    if (avg_vo !== 13'd250) begin errors++; $display("FAIL avg_vo_trunc: got %0d required 250", avg_vo); end
    @(negedge clk);
    checks++;
    if (avg_valid !== 1'b0) begin errors++; $display("FAIL avg_valid_width: still high, required 0"); end
    checks++;
    if (avg_vo !== 13'd250) begin errors++; $display("FAIL avg_vo_hold: got %0d required 250", avg_vo); end
  endtask

  task automatic test_startup();
    do_reset();
    for (int k = 0; k < 4; k++) drive_tick(13'd3000, 13'd1000, 13'd1000, 13'd3000);
    checks++;
    if (mode !== M_STARTUP) begin errors++; $display("FAIL startup_pre: mode=%0d required %0d", mode, M_STARTUP); end
    @(negedge clk);
    checks++;
    if (mode !== M_RUN) begin errors++; $display("FAIL startup_run: mode=%0d required %0d", mode, M_RUN); end
    do_reset();
    for (int k = 0; k < 8; k++) drive_tick(13'd3000, 13'd1000, 13'd1000, 13'd1500);
    idle(4);
    checks++;
    if (mode !== M_STARTUP || fault_uv !== 1'b0 || avg_vin !== 13'd1500) begin
      errors++; $display("FAIL startup_lowvin: mode=%0d uv=%0b avg_vin=%0d required 0/0/1500", mode, fault_uv, avg_vin);
    end
  endtask

  task automatic test_oc_and_clear();
    logic [12:0] seq [5];
    seq[0] = 13'd7001; seq[1] = 13'd7001; seq[2] = 13'd7000; seq[3] = 13'd7001; seq[4] = 13'd7001;
    do_reset();
    nominal_window(13'd3000, 13'd1000, 13'd3000);
    checks++;
    if (mode !== M_RUN) begin errors++; $display("FAIL oc_setup_run: mode=%0d required %0d", mode, M_RUN); end
    for (int k = 0; k < 5; k++) begin
      drive_tick(13'd3000, 13'd1000, seq[k], 13'd3000);
      idle(3);
      checks++;
      if (fault_oc !== 1'b0) begin errors++; $display("FAIL oc_early: tick %0d fault_oc=1 required 0", k); end
    end
    drive_tick(13'd3000, 13'd1000, 13'd7001, 13'd3000);
    @(negedge clk);
    checks++;
    if (fault_oc !== 1'b1 || shutdown !== 1'b0) begin
      errors++; $display("FAIL oc_set: oc=%0b shutdown=%0b required 1/0", fault_oc, shutdown);
    end
    @(negedge clk);
    checks++;
    if (shutdown !== 1'b1 || mode !== M_TRIP) begin
      errors++; $display("FAIL oc_trip: shutdown=%0b mode=%0d required 1/%0d", shutdown, mode, M_TRIP);
    end
    // Clear while the overcurrent condition still holds.
    pulse_clr();
    idle(2);
    checks++;
    if (fault_oc !== 1'b1 || mode !== M_TRIP) begin
      errors++; $display("FAIL clr_blocked: oc=%0b mode=%0d required 1/%0d", fault_oc, mode, M_TRIP);
    end
    drive_tick(13'd3000, 13'd1000, 13'd100, 13'd3000);
    idle(2);
    pulse_clr();
    checks++;
    if (act_flags !== 4'b0000 || mode !== M_STARTUP) begin
      errors++; $display("FAIL clr_ok: flags=%b mode=%0d required 0000/%0d", act_flags, mode, M_STARTUP);
    end
    @(negedge clk);
    checks++;
    if (shutdown !== 1'b0) begin errors++; $display("FAIL clr_shutdown: shutdown=1 required 0"); end
    // Clear coincident with a new over-voltage average.
    do_reset();
    nominal_window(13'd3000, 13'd1000, 13'd3000);
    for (int k = 0; k < 4; k++) drive_tick(13'd6001, 13'd1000, 13'd1000, 13'd3000);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    idle(3);
    checks++;
    if (fault_ov !== 1'b1 || mode !== M_TRIP) begin
      errors++; $display("FAIL clr_vs_set: ov=%0b mode=%0d required 1/%0d", fault_ov, mode, M_TRIP);
    end
  endtask

  task automatic test_ov_ot();
    do_reset();
    nominal_window(13'd6000, 13'd1000, 13'd3000);
    checks++;
    if (fault_ov !== 1'b0 || mode !== M_RUN) begin
      errors++; $display("FAIL ov_edge: ov=%0b mode=%0d required 0/%0d", fault_ov, mode, M_RUN);
    end
    nominal_window(13'd6001, 13'd1000, 13'd3000);
    checks++;
    if (fault_ov !== 1'b1 || mode !== M_TRIP || shutdown !== 1'b1) begin
      errors++; $display("FAIL ov_set: ov=%0b mode=%0d sd=%0b required 1/%0d/1", fault_ov, mode, shutdown, M_TRIP);
    end
    do_reset();
    nominal_window(13'd3000, 13'd1000, 13'd3000);
    nominal_window(13'd3000, 13'd5001, 13'd3000);
    checks++;
    if (fault_ot !== 1'b1 || fault_ov !== 1'b0 || mode !== M_TRIP) begin
      errors++; $display("FAIL ot_set: ot=%0b ov=%0b mode=%0d required 1/0/%0d", fault_ot, fault_ov, mode, M_TRIP);
    end
  endtask

  task automatic test_reset_midwindow();
    // Entered in TRIP with fault_ot latched and non-zero averages.
    drive_tick(13'd4000, 13'd1000, 13'd1000, 13'd3000);
    drive_tick(13'd4000, 13'd1000, 13'd1000, 13'd3000);
    @(negedge clk);
    rst = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    checks++;
    if ({avg_vo, avg_temp, avg_i, avg_vin, avg_valid, fault_ov, fault_ot, fault_oc,
         fault_uv, shutdown, mode} !== '0) begin
      errors++; $display("FAIL midwin_reset: outputs nonzero (avg_temp=%0d ot=%0b mode=%0d)", avg_temp, fault_ot, mode);
    end
    rst = 1'b0; sample_tick = 1'b0;
    for (int k = 0; k < 4; k++) drive_tick(13'd8, 13'd1000, 13'd1000, 13'd3000);
    checks++;
    if (avg_valid !== 1'b1 || avg_vo !== 13'd8) begin
      errors++; $display("FAIL midwin_avg: valid=%0b avg_vo=%0d required 1/8", avg_valid, avg_vo);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    adc_temp = 13'd1000; adc_i = 13'd1000; adc_vin = 13'd3000; sample_tick = 1'b1;
    adc_vo = 13'd10; @(negedge clk);
    adc_vo = 13'd20; @(negedge clk);
    adc_vo = 13'd30; @(negedge clk);
    adc_vo = 13'd41; @(negedge clk);
    sample_tick = 1'b0;
    checks++;
    if (avg_valid !== 1'b1 || avg_vo !== 13'd25) begin
      errors++; $display("FAIL b2b_avg: valid=%0b avg_vo=%0d required 1/25", avg_valid, avg_vo);
    end
  endtask

  task automatic test_width_corner();
    do_reset();
    for (int k = 0; k < 64; k++) begin
      drive_tick(13'd8191, 13'd8191, 13'd8191, 13'd8191);
      checks++;
      if (avg_valid6 !== (k == 63)) begin
        errors++; $display("FAIL wide_valid: tick %0d avg_valid6=%0b required %0b", k, avg_valid6, (k == 63));
      end
    end
    checks++;
    if (avg_vo6 !== 13'd8191 || avg_temp6 !== 13'd8191 || avg_i6 !== 13'd8191 || avg_vin6 !== 13'd8191) begin
      errors++; $display("FAIL wide_avg: %0d %0d %0d %0d required 8191", avg_vo6, avg_temp6, avg_i6, avg_vin6);
    end
    checks++;
    if (avg_vo !== 13'd8191 || avg_vin !== 13'd8191) begin
      errors++; $display("FAIL narrow_fullscale: avg_vo=%0d avg_vin=%0d required 8191", avg_vo, avg_vin);
    end
  endtask

  task automatic test_random();
    logic [12:0] vo, t, i, vin, exp_v;
    do_reset();
    model_reset();
    for (int s = 0; s < 80; s++) begin
      vo  = 13'($urandom_range(5400, 6100));
      t   = 13'($urandom_range(4600, 5100));
      i   = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(7001, 7100)) : 13'($urandom_range(6000, 7000));
      vin = 13'($urandom_range(1700, 3200));
      model_tick(vo, t, i, vin);
      drive_tick(vo, t, i, vin);
      checks++;
      if (avg_valid !== m_done) begin
        errors++; $display("FAIL rnd_valid: sweep %0d avg_valid=%0b required %0b", s, avg_valid, m_done);
      end
      if (avg_valid === 1'b1 && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (avg_vo !== exp_v) begin
          errors++; $display("FAIL rnd_sb_vo: sweep %0d avg_vo=%0d required %0d", s, avg_vo, exp_v);
        end
      end
      idle(4);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act_avg[k] !== 13'(m_avg[k])) begin
          errors++; $display("FAIL rnd_avg%0d: sweep %0d got %0d required %0d", k, s, act_avg[k], m_avg[k]);
        end
      end
      checks++;
      if (act_flags !== {m_uv, m_oc, m_ot, m_ov} || mode !== 2'(m_mode) ||
          shutdown !== (m_ov | m_ot | m_oc | m_uv | (m_mode == 2))) begin
        errors++; $display("FAIL rnd_prot: sweep %0d flags=%b mode=%0d sd=%0b required %b/%0d", s,
                           act_flags, mode, shutdown, {m_uv, m_oc, m_ot, m_ov}, m_mode);
      end
      if (s % 5 == 4) begin
        model_clear();
        pulse_clr();
        idle(2);
        checks++;
        if (act_flags !== {m_uv, m_oc, m_ot, m_ov} || mode !== 2'(m_mode)) begin
          errors++; $display("FAIL rnd_clear: sweep %0d flags=%b mode=%0d required %b/%0d", s,
                             act_flags, mode, {m_uv, m_oc, m_ot, m_ov}, m_mode);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_sb_drain: %0d averages never observed, required 0", exp_q.size());
    end
  endtask

  // Watchdog
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Sequence and final report
  initial begin
    test_reset();
    test_averaging();
    test_startup();
    test_oc_and_clear();
    test_ov_ot();
    test_reset_midwindow();
    test_back_to_back();
    test_random();
    test_width_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_filter_protect.md
Name: adc_filter_protect

Overview:
- Sits directly downstream of the ADC front end, between it and the SMPS control loop.
- Consumes the four demuxed 13-bit channel registers (vo, temp, i, vin) on a per-sweep strobe and produces boxcar-averaged values for the compensator.
- Runs fault detection: overcurrent (instantaneous, debounced), overvoltage, overtemperature and input undervoltage (all on averages).
- Drives a registered shutdown line and a 3-state supervisory mode.

Parameters:
- LOG2_AVG, 2: averaging window is 2^LOG2_AVG sweeps (range 0..6).
- VO_MAX, 13'd6000: averaged vo above this raises fault_ov.
- T_MAX, 13'd5000: averaged temp above this raises fault_ot.
- I_MAX, 13'd7000: instantaneous i above this counts toward overcurrent.
- OC_CNT, 3: consecutive over-limit sweeps needed to latch fault_oc (range 1..15).
- VIN_MIN, 13'd2000: averaged vin below this raises fault_uv (RUN only).

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  reset, synchronous, active-high.
- sample_tick  in  1  one-cycle pulse: all four adc_* inputs hold a fresh sweep.
- fault_clr  in  1  one-cycle request to clear latched faults.
- adc_vo  in  13  output-voltage code, unsigned straight binary.
- adc_temp  in  13  temperature code.
- adc_i  in  13  inductor-current code.
- adc_vin  in  13  input-voltage code.
- avg_vo, avg_temp, avg_i, avg_vin  out  13 each  averaged codes.
- avg_valid  out  1  one-cycle pulse when the avg_* outputs update.
- fault_ov, fault_ot, fault_oc, fault_uv  out  1 each  latched fault flags.
- shutdown  out  1  registered OR of the latched faults, plus mode==TRIP.
- mode  out  2  00 STARTUP, 01 RUN, 10 TRIP.

Behaviour:
- Reset (synchronous, active-high): every output is 0, mode=STARTUP. Accumulators, the sweep counter and the OC counter are 0. Reset mid-window discards the partial sum.
- Accumulators are 13+LOG2_AVG bits wide, one per channel, unsigned, and cannot overflow.
- On each sample_tick, every accumulator adds its input and the sweep counter increments.
- On the tick where the counter equals 2^LOG2_AVG-1:
  - avg_x <= (acc_x + adc_x) >> LOG2_AVG, truncating.
  - Accumulators and counter return to 0.
  - avg_valid is high in the cycle after that tick (latency 1 clk); avg_* hold between updates.
- Overcurrent:
  - On a tick with adc_i > I_MAX, oc_cnt increments, saturating at OC_CNT; a tick with adc_i <= I_MAX sets oc_cnt to 0.
  - fault_oc sets in the cycle after oc_cnt reaches OC_CNT.
  - Strict comparison: adc_i == I_MAX does not count.
- Averaged-value faults are evaluated in the cycle avg_valid is high, using the new avg values:
  - avg_vo > VO_MAX sets fault_ov.
  - avg_temp > T_MAX sets fault_ot.
  - avg_vin < VIN_MIN sets fault_uv, only while mode==RUN.
- Fault flags are sticky. fault_clr clears a flag only if its condition is false in that cycle. If a set condition and fault_clr occur in the same cycle, the set wins.
- shutdown is registered, 1 clk after any flag sets.
- FSM:
  - STARTUP -> RUN on the first avg_valid with avg_vin >= VIN_MIN and no fault set. In STARTUP, ov/ot/oc can set and go straight to TRIP.
  - RUN -> TRIP when any fault flag is set.
  - TRIP -> STARTUP on the cycle after fault_clr leaves all flags clear. This re-qualifies vin before RUN.
  - TRIP holds otherwise; fault_clr has no effect in STARTUP or RUN.
- sample_tick during reset is ignored. Ticks on consecutive clocks are legal, and each one counts.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_W=13.
  - Mode encodings MODE_STARTUP, MODE_RUN, MODE_TRIP.
  - A 4-bit fault-vector bit order: ov=0, ot=1, oc=2, uv=3.
- One natural sub-module, boxcar_avg: one channel, parameterised by LOG2_AVG, with ports clk, rst, tick, din, dout, dvalid. Instantiate it four times.
- Fault latches, OC debounce and the FSM live in the top.

Test Plan (LOG2_AVG=2 unless stated):
1. Averaging: 4 ticks with adc_vo=100,200,300,401 -> one cycle after the 4th tick avg_vo=250 (truncated) and avg_valid is high for exactly 1 clk.
2. Startup: 4 ticks with vin=3000 and other channels nominal -> mode goes STARTUP->RUN the cycle after avg_valid. Repeat with vin=1500 -> mode stays STARTUP and fault_uv stays 0.
3. OC debounce: in RUN, adc_i=7001 on ticks 1,2, then 7000, then 7001 x3 -> fault_oc sets only after the third of the final run. shutdown follows 1 clk later; mode=TRIP.
4. Clear semantics:
   - fault_clr while the OC condition is still true -> fault_oc stays 1.
   - After adc_i=100 on the next tick, fault_clr -> all flags 0, then mode=STARTUP.
   - fault_clr in the same cycle as a new avg_vo=6001 -> fault_ov is 1.
5. Overvoltage/overtemperature: avg_vo=6000 -> no fault; avg_vo=6001 -> fault_ov set. avg_temp=5001 -> fault_ot set.
6. Reset mid-window: 2 ticks, then rst for 1 clk, then 4 ticks of adc_vo=8 -> avg_vo=8, with no contribution from the pre-reset samples. All outputs are 0 during reset.
7. Width corner (LOG2_AVG=6): 64 ticks with all inputs at 8191 -> all avg_*=8191, with no accumulator overflow.
